// File: rtl/hash_scoreboard.sv
// Open-addressed command-ID -> processor-ID scoreboard with linear probing and tombstone deletes.
// One request in flight; each PROBE cycle inspects one slot, responses strobe o_ack in RESP.
module hash_scoreboard #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 3,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    // Handshake: a request transfers on the rising edge where i_req && o_ready;
    // operands must be stable in that cycle, o_ready is high only in IDLE.
    input  logic             i_req,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [KEY_W-1:0] i_key,
    input  logic [VAL_W-1:0] i_val,
    input  logic             i_clear,
    output logic             o_ack,
    output logic             o_hit,
    output logic             o_dup,
    output logic             o_full,
    output logic [VAL_W-1:0] o_val,
    output logic [IW-1:0]    o_idx,
    output logic [CW-1:0]    o_count,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PROBE = 2'd1, S_RESP = 2'd2} state_t;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELKEY = 2'b10;
    localparam logic [1:0] OP_DELVAL = 2'b11;

    localparam logic [1:0] SL_EMPTY = 2'd0;
    localparam logic [1:0] SL_VALID = 2'd1;
    localparam logic [1:0] SL_DEL   = 2'd2;

    state_t r_state, w_next;

    logic [1:0]       r_st  [DEPTH];
    logic [KEY_W-1:0] r_kmem[DEPTH];
    logic [VAL_W-1:0] r_vmem[DEPTH];

    logic [1:0]       r_op;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_val;
    logic [IW-1:0]    r_p;
    logic [IW-1:0]    r_n;
    logic             r_cand_v;
    logic [IW-1:0]    r_cand;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_free;
    logic             w_last;
    logic             w_key_match;
    logic             w_val_match;
    logic             w_hit;
    logic             w_done;
    logic             w_cand_v;
    logic [IW-1:0]    w_cand_idx;
    logic             w_is_del;

    assign o_ready  = (r_state == S_IDLE);
    assign o_count  = r_count;
    assign o_state  = r_state;
    assign w_accept = i_req && (r_state == S_IDLE) && !i_clear;

    // Decision logic for the slot currently under the probe index.
    always_comb begin
        w_free      = (r_st[r_p] != SL_VALID);
        w_last      = (r_n == IW'(DEPTH - 1));
        w_key_match = (r_st[r_p] == SL_VALID) && (r_kmem[r_p] == r_key);
        w_val_match = (r_st[r_p] == SL_VALID) && (r_vmem[r_p] == r_val);
        w_cand_v    = r_cand_v || w_free;
        w_cand_idx  = r_cand_v ? r_cand : r_p;
        w_is_del    = (r_op == OP_DELKEY) || (r_op == OP_DELVAL);
        w_hit       = 1'b0;
        w_done      = 1'b0;
        case (r_op)
            OP_DELVAL: begin
                w_hit  = w_val_match;
                w_done = w_val_match || w_last;
            end
            default: begin
                w_hit  = w_key_match;
                w_done = w_key_match || (r_st[r_p] == SL_EMPTY) || w_last;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = S_PROBE;
                S_PROBE: if (w_done) w_next = S_RESP;
                S_RESP:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_st[i]   <= SL_EMPTY;
                r_kmem[i] <= '0;
                r_vmem[i] <= '0;
            end
            r_op     <= OP_LOOKUP;
            r_key    <= '0;
            r_val    <= '0;
            r_p      <= '0;
            r_n      <= '0;
            r_cand_v <= 1'b0;
            r_cand   <= '0;
            r_count  <= '0;
            o_ack    <= 1'b0;
            o_hit    <= 1'b0;
            o_dup    <= 1'b0;
            o_full   <= 1'b0;
            o_val    <= '0;
            o_idx    <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_st[i] <= SL_EMPTY;
            r_count <= '0;
            o_ack   <= 1'b0;
        end else begin
            o_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= i_op;
                        r_key    <= i_key;
                        r_val    <= i_val;
                        r_p      <= (i_op == OP_DELVAL) ? '0 : i_key[IW-1:0];
                        r_n      <= '0;
                        r_cand_v <= 1'b0;
                    end
                end
                S_PROBE: begin
                    if (w_done) begin
                        o_ack  <= 1'b1;
                        o_hit  <= w_hit;
                        o_dup  <= (r_op == OP_INSERT) && w_hit;
                        o_full <= (r_op == OP_INSERT) && !w_hit && !w_cand_v;
                        o_idx  <= r_p;
                        o_val  <= r_vmem[r_p];
                        if ((r_op == OP_INSERT) && !w_hit && w_cand_v) begin
                            r_st[w_cand_idx]   <= SL_VALID;
                            r_kmem[w_cand_idx] <= r_key;
                            r_vmem[w_cand_idx] <= r_val;
                            r_count            <= r_count + CW'(1);
                            o_idx              <= w_cand_idx;
                            o_val              <= r_val;
                        end
                        if (w_is_del && w_hit) begin
                            // Removing the last live entry wipes tombstones so chains restart short.
                            if (r_count == CW'(1)) begin
                                for (int i = 0; i < DEPTH; i++) r_st[i] <= SL_EMPTY;
                            end else begin
                                r_st[r_p] <= SL_DEL;
                            end
                            r_count <= r_count - CW'(1);
                        end
                    end else begin
                        r_p <= r_p + IW'(1);
                        r_n <= r_n + IW'(1);
                        if (!r_cand_v && w_free) begin
                            r_cand_v <= 1'b1;
                            r_cand   <= r_p;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_scoreboard.sv
// Bench for hash_scoreboard: directed walk of the key scenarios plus randomized ops
// compared against an array-based reference table.
module tb_hash_scoreboard;

    localparam int DEPTH = 8;
    localparam int KEY_W = 8;
    localparam int VAL_W = 3;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELKEY = 2'b10;
    localparam logic [1:0] OP_DELVAL = 2'b11;

    logic             i_clk;
    logic             i_rstn;
    logic             i_req;
    logic             o_ready;
    logic [1:0]       i_op;
    logic [KEY_W-1:0] i_key;
    logic [VAL_W-1:0] i_val;
    logic             i_clear;
    logic             o_ack;
    logic             o_hit;
    logic             o_dup;
    logic             o_full;
    logic [VAL_W-1:0] o_val;
    logic [IW-1:0]    o_idx;
    logic [CW-1:0]    o_count;
    logic [1:0]       o_state;

    hash_scoreboard #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .o_ready(o_ready),
        .i_op(i_op), .i_key(i_key), .i_val(i_val), .i_clear(i_clear),
        .o_ack(o_ack), .o_hit(o_hit), .o_dup(o_dup), .o_full(o_full),
        .o_val(o_val), .o_idx(o_idx), .o_count(o_count), .o_state(o_state)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reference table: 0 empty, 1 live, 2 tombstone
    int m_st [DEPTH];
    int m_key[DEPTH];
    int m_val[DEPTH];
    int m_count;

    int e_hit, e_dup, e_full, e_val, e_idx, e_k;
    int l_hit, l_dup, l_full, l_val, l_idx, l_lat;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_st[i] = 0;
        m_count = 0;
    endtask

    task automatic model_op(input logic [1:0] op, input int key, input int val);
        int start, cand, found, slot;
        e_hit = 0; e_dup = 0; e_full = 0; e_val = 0; e_k = DEPTH - 1;
        start = (op == OP_DELVAL) ? 0 : key % DEPTH;
        cand = -1; found = -1;
        for (int n = 0; n < DEPTH; n++) begin
            slot = (start + n) % DEPTH;
            if (op == OP_DELVAL) begin
                if (m_st[slot] == 1 && m_val[slot] == val) begin
                    found = slot; e_k = n; break;
                end
            end else begin
                if (m_st[slot] == 1 && m_key[slot] == key) begin
                    found = slot; e_k = n; break;
                end
                if (op == OP_INSERT && m_st[slot] != 1 && cand < 0) cand = slot;
                if (m_st[slot] == 0) begin
                    e_k = n; break;
                end
            end
        end
        e_idx = (start + e_k) % DEPTH;
        if (found >= 0) begin
            e_hit = 1; e_val = m_val[found]; e_idx = found;
            if (op == OP_INSERT) e_dup = 1;
            if (op == OP_DELKEY || op == OP_DELVAL) begin
                m_st[found] = 2;
                m_count--;
                if (m_count == 0) model_reset();
            end
        end else if (op == OP_INSERT) begin
            if (cand >= 0) begin
                m_st[cand] = 1; m_key[cand] = key; m_val[cand] = val;
                m_count++;
                e_idx = cand;
            end else begin
                e_full = 1;
            end
        end
    endtask

    // driver: one request, wait for its ack, compare with the reference table
    task automatic do_op(input logic [1:0] op, input int key, input int val);
        int lat;
        bit got;
        model_op(op, key, val);
        @(negedge i_clk);
        for (int w = 0; w < 20 && !o_ready; w++) @(negedge i_clk);
        i_req = 1'b1; i_op = op; i_key = KEY_W'(key); i_val = VAL_W'(val);
        @(posedge i_clk);
        #1 i_req = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < DEPTH + 4) begin
            @(negedge i_clk);
            lat++;
            if (o_ack) got = 1;
        end
        check("ack_seen", 32'(got), 32'd1);
        l_hit = o_hit; l_dup = o_dup; l_full = o_full; l_val = o_val; l_idx = o_idx; l_lat = lat;
        if (got) begin
            check("latency", 32'(lat), 32'(e_k + 2));
            check("hit", 32'(o_hit), 32'(e_hit));
            check("dup", 32'(o_dup), 32'(e_dup));
            check("full", 32'(o_full), 32'(e_full));
            check("idx", 32'(o_idx), 32'(e_idx));
            if (e_hit != 0) check("val", 32'(o_val), 32'(e_val));
            check("count", 32'(o_count), 32'(m_count));
        end
    endtask

    task automatic do_clear();
        @(negedge i_clk);
        i_clear = 1'b1;
        @(posedge i_clk);
        #1 i_clear = 1'b0;
        model_reset();
        @(negedge i_clk);
        check("clear_count", 32'(o_count), 32'd0);
        check("clear_ready", 32'(o_ready), 32'd1);
    endtask

    int ack_seen;
    int r;

    initial begin
        i_rstn = 1'b0; i_req = 1'b0; i_op = '0; i_key = '0; i_val = '0; i_clear = 1'b0;
        model_reset();
        #22 i_rstn = 1'b1;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_idx", 32'(o_idx), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);

        do_op(OP_LOOKUP, 5, 0);
        check("empty_lookup_idx", 32'(l_idx), 32'd5);
        check("empty_lookup_lat", 32'(l_lat), 32'd2);

        do_op(OP_INSERT, 3, 1);
        check("ins3_idx", 32'(l_idx), 32'd3);
        do_op(OP_INSERT, 11, 2);
        check("ins11_idx", 32'(l_idx), 32'd4);
        do_op(OP_INSERT, 19, 4);
        check("ins19_idx", 32'(l_idx), 32'd5);
        check("chain_count", 32'(o_count), 32'd3);
        do_op(OP_LOOKUP, 19, 0);
        check("lk19_val", 32'(l_val), 32'd4);
        check("lk19_lat", 32'(l_lat), 32'd4);

        do_op(OP_DELKEY, 11, 0);
        check("del11_count", 32'(o_count), 32'd2);
        do_op(OP_LOOKUP, 19, 0);
        check("lk19_after_del", 32'(l_idx), 32'd5);
        do_op(OP_INSERT, 27, 6);
        check("ins27_idx", 32'(l_idx), 32'd4);
        check("ins27_lat", 32'(l_lat), 32'd5);

        do_op(OP_INSERT, 3, 7);
        check("dup3", 32'(l_dup), 32'd1);
        check("dup3_val", 32'(l_val), 32'd1);

        do_clear();
        do_op(OP_INSERT, 7, 0);
        check("wrap7_idx", 32'(l_idx), 32'd7);
        do_op(OP_INSERT, 15, 5);
        check("wrap15_idx", 32'(l_idx), 32'd0);

        do_clear();
        for (int k = 0; k < DEPTH; k++) do_op(OP_INSERT, k, k % 8);
        check("full_count", 32'(o_count), 32'd8);
        do_op(OP_INSERT, 8, 1);
        check("full_flag", 32'(l_full), 32'd1);
        check("full_lat", 32'(l_lat), 32'd9);
        do_op(OP_INSERT, 2, 3);
        check("full_dup", 32'(l_dup), 32'd1);

        // clear while a long lookup is probing
        @(negedge i_clk);
        i_req = 1'b1; i_op = OP_LOOKUP; i_key = 8'd8; i_val = '0;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        @(negedge i_clk);
        i_clear = 1'b1;
        @(posedge i_clk);
        #1 i_clear = 1'b0;
        model_reset();
        @(negedge i_clk);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_count", 32'(o_count), 32'd0);
        ack_seen = 0;
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (o_ack) ack_seen = 1;
            @(negedge i_clk);
        end
        check("abort_no_ack", 32'(ack_seen), 32'd0);

        do_op(OP_INSERT, 9, 4);
        do_op(OP_DELVAL, 0, 4);
        check("delval_hit", 32'(l_hit), 32'd1);
        check("delval_idx", 32'(l_idx), 32'd1);
        check("delval_count", 32'(o_count), 32'd0);
        do_op(OP_LOOKUP, 9, 0);
        check("purge_lat", 32'(l_lat), 32'd2);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       do_clear();
            else if (r < 45) do_op(OP_INSERT, $urandom_range(0, 23), $urandom_range(0, 7));
            else if (r < 65) do_op(OP_LOOKUP, $urandom_range(0, 23), 0);
            else if (r < 85) do_op(OP_DELKEY, $urandom_range(0, 23), 0);
            else             do_op(OP_DELVAL, 0, $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
